// File: rtl/dmem_axil_responder.sv
// Data-memory responder for the LSU load/store path: word reads and byte-strobed
// writes over independent AXI4-Lite-style channels with programmable response latency.
module dmem_axil_responder #(
    parameter int unsigned DEPTH      = 256,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned WR_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int unsigned IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  RD_LAT_C   = 4'(RD_LATENCY);
    localparam logic [3:0]  WR_LAT_C   = 4'(WR_LATENCY);
    localparam logic [1:0]  RESP_OKAY  = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {R_IDLE = 2'b00, R_WAIT = 2'b01, R_RESP = 2'b10} rd_state_t;
    typedef enum logic [1:0] {W_IDLE = 2'b00, W_WAIT = 2'b01, W_RESP = 2'b10} wr_state_t;

    function automatic logic addr_in_range(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return ({2'b00, off[31:2]} < 32'(DEPTH));
    endfunction

    function automatic logic [IDX_W-1:0] addr_index(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return off[IDX_W+1:2];
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return res;
    endfunction

    logic [31:0] mem_r [DEPTH];

    // ---------------- read channel ----------------
    rd_state_t        rd_state_r, rd_state_nx;
    logic [3:0]       rd_cnt_r, rd_cnt_nx;
    logic [IDX_W-1:0] rd_idx_r, rd_idx_nx;
    logic             rd_ok_r, rd_ok_nx;
    logic             ar_hs_s, rd_capture_s;
    logic             arready_r, rvalid_r;
    logic [31:0]      rdata_r;
    logic [1:0]       rresp_r;

    // Read FSM next-state, address latch and capture strobe
    always_comb begin
        rd_state_nx  = rd_state_r;
        rd_cnt_nx    = rd_cnt_r;
        rd_idx_nx    = rd_idx_r;
        rd_ok_nx     = rd_ok_r;
        ar_hs_s      = arvalid & arready_r;
        case (rd_state_r)
            R_IDLE: begin
                if (ar_hs_s) begin
                    rd_idx_nx   = addr_index(araddr);
                    rd_ok_nx    = addr_in_range(araddr);
                    rd_cnt_nx   = RD_LAT_C;
                    rd_state_nx = (RD_LAT_C == 4'd0) ? R_RESP : R_WAIT;
                end else begin
                    rd_state_nx = R_IDLE;
                end
            end
            R_WAIT: begin
                rd_cnt_nx = (rd_cnt_r != 4'd0) ? (rd_cnt_r - 4'd1) : 4'd0;
                if (rd_cnt_r <= 4'd1) begin
                    rd_state_nx = R_RESP;
                end else begin
                    rd_state_nx = R_WAIT;
                end
            end
            R_RESP: begin
                if (rvalid_r && rready) begin
                    rd_state_nx = R_IDLE;
                end else begin
                    rd_state_nx = R_RESP;
                end
            end
            default: begin
                rd_state_nx = R_IDLE;
            end
        endcase
        rd_capture_s = (rd_state_nx == R_RESP) && (rd_state_r != R_RESP);
    end

    // Read FSM state, registered ready and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_r <= R_IDLE;
            rd_cnt_r   <= 4'd0;
            rd_idx_r   <= '0;
            rd_ok_r    <= 1'b0;
            arready_r  <= 1'b0;
            rvalid_r   <= 1'b0;
            rdata_r    <= 32'd0;
            rresp_r    <= RESP_OKAY;
        end else begin
            rd_state_r <= rd_state_nx;
            rd_cnt_r   <= rd_cnt_nx;
            rd_idx_r   <= rd_idx_nx;
            rd_ok_r    <= rd_ok_nx;
            arready_r  <= (rd_state_nx == R_IDLE);
            if (rd_capture_s) begin
                // Non-blocking read of mem_r yields the pre-write word on a same-edge commit
                rvalid_r <= 1'b1;
                rdata_r  <= rd_ok_nx ? mem_r[rd_idx_nx] : 32'd0;
                rresp_r  <= rd_ok_nx ? RESP_OKAY : RESP_SLVERR;
            end else if (rvalid_r && rready) begin
                rvalid_r <= 1'b0;
            end
        end
    end

    // ---------------- write channel ----------------
    wr_state_t        wr_state_r, wr_state_nx;
    logic [3:0]       wr_cnt_r, wr_cnt_nx;
    logic [IDX_W-1:0] wr_idx_r, wr_idx_nx;
    logic             wr_ok_r, wr_ok_nx;
    logic [31:0]      wr_data_r, wr_data_nx;
    logic [3:0]       wr_strb_r, wr_strb_nx;
    logic             aw_got_r, aw_got_nx, w_got_r, w_got_nx;
    logic             aw_hs_s, w_hs_s, wr_commit_s;
    logic             awready_r, wready_r, bvalid_r;
    logic [1:0]       bresp_r;

    // Write FSM next-state, payload capture and commit strobe
    always_comb begin
        wr_state_nx = wr_state_r;
        wr_cnt_nx   = wr_cnt_r;
        wr_idx_nx   = wr_idx_r;
        wr_ok_nx    = wr_ok_r;
        wr_data_nx  = wr_data_r;
        wr_strb_nx  = wr_strb_r;
        aw_got_nx   = aw_got_r;
        w_got_nx    = w_got_r;
        aw_hs_s     = awvalid & awready_r;
        w_hs_s      = wvalid & wready_r;
        case (wr_state_r)
            W_IDLE: begin
                if (aw_hs_s) begin
                    wr_idx_nx = addr_index(awaddr);
                    wr_ok_nx  = addr_in_range(awaddr);
                    aw_got_nx = 1'b1;
                end else begin
                    aw_got_nx = aw_got_r;
                end
                if (w_hs_s) begin
                    wr_data_nx = wdata;
                    wr_strb_nx = wstrb;
                    w_got_nx   = 1'b1;
                end else begin
                    w_got_nx = w_got_r;
                end
                if (aw_got_nx && w_got_nx) begin
                    wr_cnt_nx   = WR_LAT_C;
                    wr_state_nx = (WR_LAT_C == 4'd0) ? W_RESP : W_WAIT;
                end else begin
                    wr_state_nx = W_IDLE;
                end
            end
            W_WAIT: begin
                wr_cnt_nx = (wr_cnt_r != 4'd0) ? (wr_cnt_r - 4'd1) : 4'd0;
                if (wr_cnt_r <= 4'd1) begin
                    wr_state_nx = W_RESP;
                end else begin
                    wr_state_nx = W_WAIT;
                end
            end
            W_RESP: begin
                if (bvalid_r && bready) begin
                    wr_state_nx = W_IDLE;
                end else begin
                    wr_state_nx = W_RESP;
                end
            end
            default: begin
                wr_state_nx = W_IDLE;
            end
        endcase
        wr_commit_s = (wr_state_nx == W_RESP) && (wr_state_r != W_RESP);
        if (wr_commit_s) begin
            aw_got_nx = 1'b0;
            w_got_nx  = 1'b0;
        end else begin
            aw_got_nx = aw_got_nx;
            w_got_nx  = w_got_nx;
        end
    end

    // Write FSM state, capture flags, registered readys and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_r <= W_IDLE;
            wr_cnt_r   <= 4'd0;
            wr_idx_r   <= '0;
            wr_ok_r    <= 1'b0;
            wr_data_r  <= 32'd0;
            wr_strb_r  <= 4'd0;
            aw_got_r   <= 1'b0;
            w_got_r    <= 1'b0;
            awready_r  <= 1'b0;
            wready_r   <= 1'b0;
            bvalid_r   <= 1'b0;
            bresp_r    <= RESP_OKAY;
        end else begin
            wr_state_r <= wr_state_nx;
            wr_cnt_r   <= wr_cnt_nx;
            wr_idx_r   <= wr_idx_nx;
            wr_ok_r    <= wr_ok_nx;
            wr_data_r  <= wr_data_nx;
            wr_strb_r  <= wr_strb_nx;
            aw_got_r   <= aw_got_nx;
            w_got_r    <= w_got_nx;
            awready_r  <= (wr_state_nx == W_IDLE) && !aw_got_nx;
            wready_r   <= (wr_state_nx == W_IDLE) && !w_got_nx;
            if (wr_commit_s) begin
                bvalid_r <= 1'b1;
                bresp_r  <= wr_ok_nx ? RESP_OKAY : RESP_SLVERR;
            end else if (bvalid_r && bready) begin
                bvalid_r <= 1'b0;
            end
        end
    end

    // Storage array: updated only on the commit edge, never reset
    always_ff @(posedge clk) begin
        if (!rst && wr_commit_s && wr_ok_nx) begin
            mem_r[wr_idx_nx] <= merge_bytes(mem_r[wr_idx_nx], wr_data_nx, wr_strb_nx);
        end
    end

    assign arready = arready_r;
    assign rvalid  = rvalid_r;
    assign rdata   = rdata_r;
    assign rresp   = rresp_r;
    assign awready = awready_r;
    assign wready  = wready_r;
    assign bvalid  = bvalid_r;
    assign bresp   = bresp_r;

endmodule

// File: tb/tb_dmem_axil_responder.sv
// Randomized self-checking bench for dmem_axil_responder against a word-array
// reference model, plus directed reset, strobe, ordering, range and collision cases.
module tb_dmem_axil_responder;

    localparam int unsigned DEPTH  = 256;
    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam int unsigned RD_LAT = 1;
    localparam int unsigned WR_LAT = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] araddr;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid, rready;
    logic [31:0] awaddr;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] ref_mem [DEPTH];

    dmem_axil_responder #(
        .DEPTH(DEPTH), .BASE_ADDR(BASE), .RD_LATENCY(RD_LAT), .WR_LATENCY(WR_LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit in_range(input logic [31:0] addr);
        longint unsigned off;
        off = (longint'(addr) - longint'(BASE) + 64'h1_0000_0000) % 64'h1_0000_0000;
        return (off / 4) < DEPTH;
    endfunction

    function automatic int word_of(input logic [31:0] addr);
        longint unsigned off;
        off = (longint'(addr) - longint'(BASE) + 64'h1_0000_0000) % 64'h1_0000_0000;
        return int'((off / 4) % DEPTH);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Write transaction; hold_b cycles of bready low. Checks latency, response, stability.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int hold_b);
        bit aw_done = 1'b0, w_done = 1'b0, aw_fire, w_fire;
        int t = 0, n;
        logic [1:0] exp_resp;
        awaddr = addr; wdata = data; wstrb = strb;
        while (!(aw_done && w_done) && t < 60) begin
            awvalid = !aw_done && (t >= aw_dly);
            wvalid  = !w_done && (t >= w_dly);
            if (w_done) chk("wready_after_w", 32'(wready), 32'd0);
            if (aw_done) chk("awready_after_aw", 32'(awready), 32'd0);
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            step();
            aw_done |= aw_fire;
            w_done  |= w_fire;
            t++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        if (!(aw_done && w_done)) begin
            chk("wr_hs_timeout", 32'd0, 32'd1);
            return;
        end
        // Edges counted inclusive of the capture edge
        n = 1;
        while (!bvalid && n < 60) begin
            step();
            n++;
        end
        chk("wr_latency", 32'(n), 32'(WR_LAT + 1));
        exp_resp = in_range(addr) ? 2'b00 : 2'b10;
        chk("bresp", 32'(bresp), 32'(exp_resp));
        for (int i = 0; i < hold_b; i++) begin
            awvalid = 1'($urandom_range(0, 1));
            wvalid  = 1'($urandom_range(0, 1));
            step();
            chk("bvalid_hold", 32'(bvalid), 32'd1);
            chk("bresp_hold", 32'(bresp), 32'(exp_resp));
        end
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        step();
        bready = 1'b0;
        chk("bvalid_drop", 32'(bvalid), 32'd0);
        if (in_range(addr)) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) ref_mem[word_of(addr)][8*b +: 8] = data[8*b +: 8];
            end
        end
    endtask

    // Read transaction; hold_r cycles of rready low. Returns the data seen.
    task automatic do_read(input logic [31:0] addr, input int ar_dly, input int hold_r,
                           output logic [31:0] got);
        int t = 0, n;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        bit fire = 1'b0;
        got = 32'd0;
        araddr = addr;
        while (!fire && t < 60) begin
            arvalid = (t >= ar_dly);
            fire = arvalid && arready;
            step();
            t++;
        end
        arvalid = 1'b0;
        if (!fire) begin
            chk("rd_hs_timeout", 32'd0, 32'd1);
            return;
        end
        exp_data = in_range(addr) ? ref_mem[word_of(addr)] : 32'd0;
        exp_resp = in_range(addr) ? 2'b00 : 2'b10;
        n = 1;
        while (!rvalid && n < 60) begin
            step();
            n++;
        end
        chk("rd_latency", 32'(n), 32'(RD_LAT + 1));
        got = rdata;
        chk("rdata", rdata, exp_data);
        chk("rresp", 32'(rresp), 32'(exp_resp));
        for (int i = 0; i < hold_r; i++) begin
            arvalid = 1'($urandom_range(0, 1));
            step();
            chk("rvalid_hold", 32'(rvalid), 32'd1);
            chk("rdata_hold", rdata, exp_data);
        end
        arvalid = 1'b0; rready = 1'b1;
        step();
        rready = 1'b0;
        chk("rvalid_drop", 32'(rvalid), 32'd0);
    endtask

    logic [31:0] rd_v, rd_v2, rnd_addr;

    initial begin
        rst = 1'b1;
        araddr = BASE; awaddr = BASE; wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
        arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
        rready = 1'b0; bready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_ready", {29'd0, arready, awready, wready}, 32'd0);
            chk("rst_valid", {30'd0, rvalid, bvalid}, 32'd0);
            chk("rst_resp", {rdata[29:0], rresp}, 32'd0);
            chk("rst_bresp", 32'(bresp), 32'd0);
        end
        rst = 1'b0; arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        step();
        chk("post_rst_ready", {29'd0, arready, awready, wready}, 32'd7);

        for (int i = 0; i < DEPTH; i++) begin
            do_write(BASE + 32'(4 * i), $urandom, 4'hF, 0, 0, 0);
        end

        do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
        do_read(32'h8000_0013, 0, 0, rd_v);
        chk("roundtrip", rd_v, 32'hDEAD_BEEF);
        do_write(32'h8000_0010, 32'h0000_AA00, 4'b0010, 0, 0, 0);
        do_read(32'h8000_0010, 0, 0, rd_v);
        chk("byte_strobe", rd_v, 32'hDEAD_AAEF);
        do_write(32'h8000_0010, 32'h1234_5678, 4'b0000, 0, 0, 0);
        do_read(32'h8000_0010, 0, 0, rd_v);
        chk("zero_strobe", rd_v, 32'hDEAD_AAEF);

        do_write(32'h8000_0020, 32'hCAFE_F00D, 4'hF, 3, 0, 5);
        do_read(32'h8000_0020, 0, 5, rd_v);
        chk("split_write", rd_v, 32'hCAFE_F00D);

        do_read(32'h7FFF_FFFC, 0, 0, rd_v);
        chk("oor_low", rd_v, 32'd0);
        do_read(BASE + 32'(4 * DEPTH), 0, 0, rd_v);
        chk("oor_high", rd_v, 32'd0);
        do_write(BASE + 32'(4 * DEPTH), 32'h5555_AAAA, 4'hF, 0, 0, 0);
        do_read(BASE, 0, 0, rd_v);
        do_read(BASE + 32'(4 * (DEPTH - 1)), 0, 0, rd_v);

        do_write(32'h8000_0040, 32'h1111_1111, 4'hF, 0, 0, 0);
        fork
            do_read(32'h8000_0040, 0, 0, rd_v);
            do_write(32'h8000_0040, 32'h2222_2222, 4'hF, 0, 0, 0);
        join
        chk("collision_old", rd_v, 32'h1111_1111);
        do_read(32'h8000_0040, 0, 0, rd_v2);
        chk("collision_new", rd_v2, 32'h2222_2222);

        awaddr = 32'h8000_0040; wdata = 32'h3333_3333; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rst_abandon_bvalid", 32'(bvalid), 32'd0);
        end
        do_read(32'h8000_0040, 0, 0, rd_v);
        chk("rst_abandon_mem", rd_v, 32'h2222_2222);

        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 9) == 0) begin
                rnd_addr = $urandom;
            end else begin
                rnd_addr = BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
            end
            if ($urandom_range(0, 1) == 1) begin
                do_write(rnd_addr, $urandom, 4'($urandom_range(0, 15)),
                         $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            end else begin
                do_read(rnd_addr, $urandom_range(0, 2), $urandom_range(0, 3), rd_v);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
